// File: rtl/rca_config.sv
// Shared configuration types for the reconfigurable compute array OUs.
package rca_config;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2,
        SHIFT_ROR = 2'd3
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_ou_state_t;

    // Width of a shift-amount field for a given operand width (at least 1 bit).
    function automatic int shamt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One iteration of the multi-cycle shifter: shifts op by k (0..STEP) in the
// compile-time selected mode. Only the positions reachable in one pass are built.
module shift_step
    import rca_config::*;
#(
    parameter int          WIDTH   = 32,
    parameter int          STEP    = 4,
    parameter shift_mode_t MODE    = SHIFT_SRA,
    parameter int          SHAMT_W = shamt_width(WIDTH)
) (
    input  logic [WIDTH-1:0]   op_i,
    input  logic [SHAMT_W-1:0] k_i,
    output logic [WIDTH-1:0]   res_o
);

    // Largest distance a single pass must handle; shift amounts never reach WIDTH.
    localparam int KMAX = (STEP < WIDTH) ? STEP : WIDTH - 1;

    logic [WIDTH-1:0] cand [KMAX+1];
    logic [WIDTH-1:0] res;

    // Each candidate is a fixed-distance shift, so it is pure wiring.
    for (genvar i = 0; i <= KMAX; i++) begin : g_pos
        if (i == 0) begin : g_zero
            assign cand[i] = op_i;
        end else if (MODE == SHIFT_SLL) begin : g_sll
            assign cand[i] = {op_i[WIDTH-1-i:0], {i{1'b0}}};
        end else if (MODE == SHIFT_SRL) begin : g_srl
            assign cand[i] = {{i{1'b0}}, op_i[WIDTH-1:i]};
        end else if (MODE == SHIFT_SRA) begin : g_sra
            assign cand[i] = {{i{op_i[WIDTH-1]}}, op_i[WIDTH-1:i]};
        end else begin : g_ror
            assign cand[i] = {op_i[i-1:0], op_i[WIDTH-1:i]};
        end
    end

    // Bounded barrel: pick the candidate matching the requested distance.
    always_comb begin
        res = op_i;
        for (int i = 1; i <= KMAX; i++) begin
            if (k_i == SHAMT_W'(i)) res = cand[i];
        end
    end

    assign res_o = res;

endmodule

// File: rtl/shift_ou.sv
// Multi-cycle shift operation unit: accepts an operand pair, shifts by up to
// STEP positions per cycle and holds the result until downstream acknowledges.
module shift_ou
    import rca_config::*;
#(
    parameter int          XLEN  = 32,
    parameter int          WIDTH = XLEN,
    parameter shift_mode_t MODE  = SHIFT_SRA,
    parameter int          STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic             data_valid_in1,
    input  logic             data_valid_in2,
    output logic             data_in_ack1,
    output logic             data_in_ack2,
    output logic             uses_data_in1,
    output logic             uses_data_in2,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid_out,
    input  logic             data_out_ack,
    output logic [XLEN-1:0]  addr,
    output logic [XLEN-1:0]  data,
    output logic [2:0]       fn3,
    output logic             load,
    output logic             store,
    output logic             new_request,
    input  logic             lsq_full,
    input  logic [XLEN-1:0]  load_data,
    input  logic             load_complete
);

    localparam int SHAMT_W = shamt_width(WIDTH);
    localparam int KMAX    = (STEP < WIDTH) ? STEP : WIDTH - 1;
    localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(KMAX);

    if (STEP < 1) begin : g_bad_step
        $error("shift_ou: STEP must be at least 1");
    end
    if (MODE != SHIFT_SLL && MODE != SHIFT_SRL &&
        MODE != SHIFT_SRA && MODE != SHIFT_ROR) begin : g_bad_mode
        $error("shift_ou: illegal MODE");
    end

    shift_ou_state_t    state_q;
    logic [WIDTH-1:0]   op_q, op_d;
    logic [SHAMT_W-1:0] rem_q, k, amt;
    logic               dv_q;
    logic               accept;

    // LSQ port is not used by this OU; fold unused inputs so lint stays quiet.
    logic unused_inputs;
    assign unused_inputs = ^{lsq_full, load_data, load_complete, data_in2};

    assign amt = data_in2[SHAMT_W-1:0];
    assign k   = (rem_q > STEP_C) ? STEP_C : rem_q;

    // Reset gates the handshake so no operand is acknowledged while held in reset.
    assign accept = rst && data_valid_in1 && data_valid_in2 &&
                    (state_q == IDLE || (state_q == DONE && data_out_ack));

    shift_step #(
        .WIDTH  (WIDTH),
        .STEP   (STEP),
        .MODE   (MODE),
        .SHAMT_W(SHAMT_W)
    ) u_step (
        .op_i (op_q),
        .k_i  (k),
        .res_o(op_d)
    );

    // Control FSM with the operand/remaining-count datapath and registered valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            rem_q   <= '0;
            dv_q    <= 1'b0;
        end else if (accept) begin
            // Also covers the back-to-back case from DONE: no bubble.
            op_q  <= data_in1;
            rem_q <= amt;
            if (amt != '0) begin
                state_q <= SHIFT;
                dv_q    <= 1'b0;
            end else begin
                state_q <= DONE;
                dv_q    <= 1'b1;
            end
        end else begin
            case (state_q)
                SHIFT: begin
                    op_q  <= op_d;
                    rem_q <= rem_q - k;
                    if (rem_q <= STEP_C) begin
                        state_q <= DONE;
                        dv_q    <= 1'b1;
                    end
                end
                DONE: begin
                    if (data_out_ack) begin
                        state_q <= IDLE;
                        dv_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_in_ack1   = accept;
    assign data_in_ack2   = accept;
    assign uses_data_in1  = 1'b1;
    assign uses_data_in2  = 1'b1;
    assign data_out       = op_q;
    assign data_valid_out = dv_q;

    assign addr        = '0;
    assign data        = '0;
    assign fn3         = '0;
    assign load        = 1'b0;
    assign store       = 1'b0;
    assign new_request = 1'b0;

endmodule

// File: tb/tb_shift_ou.sv
// Bench for shift_ou: one instance per shift mode, all driven by the same
// stimulus and compared against a whole-shift reference model.
module tb_shift_ou;
    import rca_config::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in1 = '0, in2 = '0;
    logic        v1 = 1'b0, v2 = 1'b0, oack = 1'b0;
    logic        lsq_full = 1'b0, load_complete = 1'b0;
    logic [31:0] load_data = '0;

    logic [31:0] dout [4];
    logic        dv [4], ack1 [4], ack2 [4], use1 [4], use2 [4];
    logic [31:0] addr [4], dat [4];
    logic [2:0]  fn3 [4];
    logic        ld [4], st [4], nreq [4];

    int nassert = 0;
    int nfail   = 0;
    logic [31:0] held [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        shift_ou #(.XLEN(32), .WIDTH(32), .MODE(shift_mode_t'(g)), .STEP(4)) dut (
            .clk(clk), .rst(rst),
            .data_in1(in1), .data_in2(in2),
            .data_valid_in1(v1), .data_valid_in2(v2),
            .data_in_ack1(ack1[g]), .data_in_ack2(ack2[g]),
            .uses_data_in1(use1[g]), .uses_data_in2(use2[g]),
            .data_out(dout[g]), .data_valid_out(dv[g]), .data_out_ack(oack),
            .addr(addr[g]), .data(dat[g]), .fn3(fn3[g]),
            .load(ld[g]), .store(st[g]), .new_request(nreq[g]),
            .lsq_full(lsq_full), .load_data(load_data), .load_complete(load_complete)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Whole-distance reference shift, straight from the mode definitions.
    function automatic logic [31:0] ref_shift(input int mode, input logic [31:0] x, input int n);
        logic [63:0] dbl;
        case (mode)
            0: return x << n;
            1: return x >> n;
            2: return 32'($signed(x) >>> n);
            default: begin
                dbl = {x, x} >> n;
                return dbl[31:0];
            end
        endcase
    endfunction

    task automatic chk_acks(input string tag, input logic exp);
        for (int m = 0; m < 4; m++) begin
            chk({tag, "_ack1"}, 32'(ack1[m]), 32'(exp));
            chk({tag, "_ack2"}, 32'(ack2[m]), 32'(exp));
        end
    endtask

    // Issue an operation starting just after a rising edge; returns at the
    // falling edge of the cycle in which the result becomes valid.
    task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b, input logic ack);
        int n, lat, cyc;
        bit seen;
        in1 = a; in2 = b; v1 = 1'b1; v2 = 1'b1; oack = ack;
        @(negedge clk);
        chk_acks({tag, "_accept"}, 1'b1);
        @(posedge clk); #1;
        v1 = 1'b0; v2 = 1'b0; oack = 1'b0;
        in1 = $urandom; in2 = $urandom;
        n   = int'(b[4:0]);
        lat = 1 + (n + 3) / 4;
        seen = 1'b0;
        cyc  = 1;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (dv[0]) begin
                seen = 1'b1;
                cyc  = c;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, cyc, lat);
        for (int m = 0; m < 4; m++) begin
            held[m] = ref_shift(m, a, n);
            chk({tag, "_dv"}, 32'(dv[m]), 32'd1);
            chk({tag, "_data"}, dout[m], held[m]);
        end
    endtask

    // Acknowledge the held result with no new operands; valid must drop.
    task automatic release_out(input string tag);
        @(posedge clk); #1;
        oack = 1'b1;
        @(posedge clk); #1;
        oack = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 4; m++) chk({tag, "_idle_dv"}, 32'(dv[m]), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset held with both operands valid: nothing may be acknowledged.
        v1 = 1'b1; v2 = 1'b1; in1 = 32'hDEAD_BEEF; in2 = 32'd3;
        #3;
        for (int m = 0; m < 4; m++) begin
            chk("rst_dout", dout[m], 32'd0);
            chk("rst_dv", 32'(dv[m]), 32'd0);
            chk("rst_uses", 32'({use1[m], use2[m]}), 32'd3);
            chk("lsq_zero", addr[m] | dat[m] | 32'(fn3[m]) | 32'({ld[m], st[m], nreq[m]}), 32'd0);
        end
        chk_acks("rst", 1'b0);
        @(posedge clk); @(posedge clk); #1;
        v1 = 1'b0; v2 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        issue("sra4", 32'h8000_0000, 32'd4, 1'b0);
        chk("sra4_const", dout[2], 32'hF800_0000);
        release_out("sra4");
        issue("zero", 32'h1234_5678, 32'd0, 1'b0);
        chk("zero_const", dout[2], 32'h1234_5678);
        release_out("zero");
        issue("srl_mask", 32'hF000_0000, 32'h0000_0025, 1'b0);
        chk("srl_mask_const", dout[1], 32'h0780_0000);
        release_out("srl_mask");
        issue("ror31", 32'h0000_0001, 32'd31, 1'b0);
        chk("ror31_const", dout[3], 32'h0000_0002);

        // Backpressure: new operands waiting while the result is unacknowledged.
        @(posedge clk); #1;
        in1 = 32'hCAFE_F00D; in2 = 32'd7; v1 = 1'b1; v2 = 1'b1; oack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk_acks("bp", 1'b0);
            for (int m = 0; m < 4; m++) begin
                chk("bp_dv", 32'(dv[m]), 32'd1);
                chk("bp_hold", dout[m], held[m]);
            end
            @(posedge clk); #1;
        end
        // Acknowledge together with new operands: accepted in the same cycle.
        issue("b2b", 32'hCAFE_F00D, 32'd7, 1'b1);
        issue("b2b0", 32'h8765_4321, 32'd0, 1'b1);
        release_out("b2b");

        // Only one operand valid: never acknowledged.
        in1 = 32'h1111_1111; in2 = 32'd2; v1 = 1'b1; v2 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_acks("single", 1'b0);
            chk("single_dv", 32'(dv[0]), 32'd0);
            @(posedge clk); #1;
        end
        v1 = 1'b0;

        // Reset while shifting with 9 positions still to go.
        in1 = 32'h9ABC_DEF0; in2 = 32'd13; v1 = 1'b1; v2 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0; v2 = 1'b0;
        @(posedge clk); #1;
        v1 = 1'b1; v2 = 1'b1;
        rst = 1'b0;
        #1;
        for (int m = 0; m < 4; m++) begin
            chk("midrst_dout", dout[m], 32'd0);
            chk("midrst_dv", 32'(dv[m]), 32'd0);
        end
        chk_acks("midrst", 1'b0);
        v1 = 1'b0; v2 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        issue("post_rst", 32'h9ABC_DEF0, 32'd13, 1'b0);

        // Randomized operations, mixing idle release and back-to-back accept.
        for (int r = 0; r < 16; r++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(1, 0) == 1) begin
                @(posedge clk); #1;
                issue("rand_b2b", ra, rb, 1'b1);
            end else begin
                release_out("rand");
                issue("rand", ra, rb, 1'b0);
            end
        end
        release_out("final");

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule

// File: doc/shift_ou.md
# shift_ou

Parametrised multi-cycle shift operation unit for the reconfigurable compute array (RCA). It is the successor to the fixed single-cycle arithmetic-right-shift OU and has four main differences. The shift mode is selected by parameter: SLL, SRL, SRA or ROR. Data width and bits-shifted-per-cycle are configurable, so area can be traded against latency. Results are held in an output register until the downstream consumer acknowledges them. It uses the standard OU port set, including a tied-off LSQ interface.

## Interface
Parameters:
- WIDTH, XLEN (32): operand and result width.
- MODE, SHIFT_SRA: shift_mode_t value, one of SHIFT_SLL, SHIFT_SRL, SHIFT_SRA or SHIFT_ROR.
- STEP, 4: maximum shift distance per cycle, legal range 1..WIDTH; STEP ≥ WIDTH gives a one-pass shift.

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in1  in  WIDTH  operand to be shifted.
- data_in2  in  WIDTH  shift amount; only bits [SHAMT_W-1:0] are used, SHAMT_W = $clog2(WIDTH).
- data_valid_in1 / data_valid_in2  in  1  operand valids.
- data_in_ack1 / data_in_ack2  out  1  operand consumed this cycle.
- uses_data_in1 / uses_data_in2  out  1  constant 1.
- data_out  out  WIDTH  result register.
- data_valid_out  out  1  result valid.
- data_out_ack  in  1  downstream has consumed the result.
- addr, data  out  XLEN  LSQ request fields, constant 0.
- fn3  out  3  LSQ request field, constant 0.
- load, store, new_request  out  1  LSQ request controls, constant 0.
- lsq_full  in  1  unused.
- load_data  in  XLEN  unused.
- load_complete  in  1  unused.

## Operation
- Registers:
  - state: IDLE, SHIFT or DONE.
  - op: WIDTH bits.
  - rem: SHAMT_W bits.
- accept = data_valid_in1 && data_valid_in2 && (state==IDLE || (state==DONE && data_out_ack)).
- data_in_ack1 = data_in_ack2 = accept (combinational).
  - A single valid operand is never acknowledged.
  - Both acks always assert together.
- On accept:
  - op ← data_in1.
  - rem ← data_in2[SHAMT_W-1:0].
  - state ← SHIFT if that amount is non-zero, otherwise DONE.
- In SHIFT, each cycle:
  - k = min(rem, STEP).
  - op ← shift(op, k, MODE).
  - rem ← rem − k.
  - state ← DONE when rem ≤ STEP; otherwise stay in SHIFT.
- In DONE:
  - data_valid_out = 1 and data_out = op, both held stable until data_out_ack.
  - data_out_ack without accept → IDLE.
  - data_out_ack with accept → the new operation is captured in the same cycle (back-to-back).
- In IDLE, data_out_ack is ignored.
- Mode semantics:
  - SLL fills with 0 from the LSB.
  - SRL fills with 0 from the MSB.
  - SRA fills with op[WIDTH-1]; the sign is preserved across iterations.
  - ROR rotates right, so bit 0 moves to bit WIDTH-1.
- data_valid_out = (state==DONE); it is registered and has no combinational path from the inputs.
- lsq_full, load_data and load_complete are ignored.

## Timing
- The accept cycle is cycle 0. data_valid_out rises in cycle 1 + ceil(n/STEP), where n is the masked shift amount.
  - n = 0 gives 1 cycle.
  - WIDTH 32, STEP 4, n = 13 gives 5 cycles.
  - STEP ≥ WIDTH gives 2 cycles for any n > 0.
- Throughput is one result per (1 + ceil(n/STEP)) cycles with back-to-back accept; no bubble is added in DONE.
- Reset (rst low), taken immediately and independent of clk:
  - state = IDLE, op = 0, rem = 0.
  - data_out = 0, data_valid_out = 0, acks = 0.
  - An in-flight operation is discarded.
- Release of rst takes effect from the next clk edge.

## Structure
- Shared package rca_config holds:
  - shift_mode_t, a 2-bit enum: SHIFT_SLL = 0, SHIFT_SRL = 1, SHIFT_SRA = 2, SHIFT_ROR = 3.
  - shift_ou_state_t, an enum: IDLE, SHIFT, DONE.
- Sub-module shift_step is combinational:
  - Inputs: op, k (SHAMT_W bits), MODE.
  - Output: the shifted op.
  - It is a bounded barrel of STEP positions plus mode fill/rotate logic, reused for all modes.
- The top level holds the FSM, the rem counter and the handshake logic.
- Elaboration-time assertions check STEP ≥ 1 and that MODE is legal.

## Test plan
All scenarios use WIDTH = 32 and STEP = 4.
- SRA: in1 = 0x8000_0000, in2 = 4, both valid in cycle 0 → acks high in cycle 0; data_valid_out rises in cycle 2 with data_out = 0xF800_0000.
- SRA, zero shift: in1 = 0x1234_5678, in2 = 0 → valid in cycle 1, data_out = 0x1234_5678.
- SRL, upper bits ignored: in1 = 0xF000_0000, in2 = 0x0000_0025 (masked amount 5) → valid in cycle 3, data_out = 0x0780_0000.
- ROR: in1 = 0x0000_0001, in2 = 31 → valid in cycle 9, data_out = 0x0000_0002.
- Backpressure and single-valid cases:
  - In DONE, hold data_out_ack = 0 for 10 cycles with both inputs valid → data_out is stable and no ack is issued.
  - Then pulse data_out_ack with new operands → the new operands are acked in that same cycle.
  - valid1 alone for 5 cycles → never acked.
- Reset mid-operation: assert rst low during SHIFT with rem = 9 → all outputs read 0 immediately; after release, a new operation completes with the correct latency and result.
